tone_gen: RTL and testbench

- Consumes the x100 frequency word from the note/octave frequency calculator and produces an audible square wave on a single output pin.
- Converts freq_x100 to a half-period cycle count using an iterative sequential divider, then runs a toggle counter.
- Sits between the frequency calculator and the speaker/PWM pad driver.
- A new frequency is accepted through a valid/ready handshake and is applied glitch-free at the next toggle boundary.

---
 rtl/tone_pkg.sv | 25 ++
 rtl/seq_divider.sv | 85 ++++++++
 rtl/tone_gen.sv | 169 ++++++++++++++++
 tb/tb_tone_gen.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tone_pkg
//  Purpose  : Shared types and constants for the tone generator.
//  Revision : 1.0  initial release
// ============================================================================
package tone_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DIV  = 1'b1
    } ctrl_state_t;

    localparam int unsigned DEF_CLK_HZ = 50_000_000;
    localparam int          DEF_CNT_W  = 32;

    localparam logic [DEF_CNT_W-1:0] ONE = DEF_CNT_W'(1);

    // Half-period dividend: (CLK_HZ * 100) / 2, since freq_x100 carries a x100 scale.
    function automatic logic [63:0] dividend_for(input logic [63:0] clk_hz);
        return clk_hz * 64'd50;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Restoring unsigned divider, one quotient bit per clock,
//             fixed latency of W cycles from start to done.
//  Revision : 1.0  initial release
// ============================================================================
module seq_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int c_cnt_w = $clog2(W + 1);

    logic [W-1:0]       r_rem;
    logic [W-1:0]       r_q;
    logic [W-1:0]       r_dsr;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;

    logic [W-1:0] w_rem_src;
    logic [W-1:0] w_q_src;
    logic [W-1:0] w_dsr;
    logic [W:0]   w_trial;
    logic [W-1:0] w_diff;
    logic         w_ge;
    logic [W-1:0] w_rem_nxt;
    logic [W-1:0] w_q_nxt;

    // The start cycle already performs the first iteration, so the last
    // quotient bit lands W cycles after start.
    always_comb begin
        w_rem_src = start ? '0 : r_rem;
        w_q_src   = start ? dividend : r_q;
        w_dsr     = start ? divisor : r_dsr;
        w_trial   = {w_rem_src, w_q_src[W-1]};
        w_ge      = (w_trial >= {1'b0, w_dsr});
        w_diff    = w_trial[W-1:0] - w_dsr;
        w_rem_nxt = w_ge ? w_diff : w_trial[W-1:0];
        w_q_nxt   = {w_q_src[W-2:0], w_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_q    <= '0;
            r_dsr  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_rem  <= w_rem_nxt;
                r_q    <= w_q_nxt;
                r_dsr  <= divisor;
                r_cnt  <= c_cnt_w'(W - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_rem_nxt;
                r_q   <= w_q_nxt;
                r_cnt <= r_cnt - c_cnt_w'(1);
                if (r_cnt == c_cnt_w'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign quotient = r_q;

endmodule
`default_nettype wire

// File: rtl/tone_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tone_gen
//  Purpose  : Square-wave tone generator; converts a x100 frequency word to a
//             half-period and toggles the output, retuning glitch-free.
//  Revision : 1.0  initial release
// ============================================================================
module tone_gen
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEF_CLK_HZ,
    parameter int          FREQ_W = 20,
    parameter int          CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freq_valid,
    output logic              freq_ready,
    input  logic [FREQ_W-1:0] freq_x100,
    input  logic              enable,
    output logic              tone_out,
    output logic              active,
    output logic [CNT_W-1:0]  half_period
);

    localparam logic [CNT_W-1:0] c_dividend = CNT_W'(dividend_for(64'(CLK_HZ)));
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(ONE);

    ctrl_state_t      r_state;
    logic             r_ready;
    logic [CNT_W-1:0] r_res;
    logic             r_res_vld;

    logic [CNT_W-1:0] r_hp;
    logic [CNT_W-1:0] r_pend;
    logic             r_pend_vld;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tone;
    logic             r_active;

    logic             w_xfer;
    logic             w_mute;
    logic             w_start;
    logic             w_div_busy;
    logic             w_div_done;
    logic [CNT_W-1:0] w_quot;

    logic [CNT_W-1:0] w_hp_n;
    logic [CNT_W-1:0] w_pend_n;
    logic             w_pend_vld_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic             w_tone_n;
    logic             w_active_n;

    assign w_xfer  = freq_valid && r_ready;
    assign w_mute  = w_xfer && (freq_x100 == '0);
    assign w_start = w_xfer && (freq_x100 != '0) && !w_div_busy;

    seq_divider #(
        .W (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_start),
        .dividend (c_dividend),
        .divisor  (CNT_W'(freq_x100)),
        .busy     (w_div_busy),
        .done     (w_div_done),
        .quotient (w_quot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ready   <= 1'b1;
            r_res     <= '0;
            r_res_vld <= 1'b0;
        end else begin
            r_res_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= DIV;
                        r_ready <= 1'b0;
                    end
                end
                DIV: begin
                    if (w_div_done) begin
                        r_state   <= IDLE;
                        r_ready   <= 1'b1;
                        // A zero quotient means faster than clk/2; pin to the maximum rate.
                        r_res     <= (w_quot == '0) ? c_one : w_quot;
                        r_res_vld <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_hp_n       = r_hp;
        w_pend_n     = r_pend;
        w_pend_vld_n = r_pend_vld;
        w_cnt_n      = r_cnt;
        w_tone_n     = r_tone;
        if (w_mute) begin
            w_hp_n       = '0;
            w_pend_vld_n = 1'b0;
            w_cnt_n      = '0;
            w_tone_n     = 1'b0;
        end else if (r_res_vld && (r_hp == '0)) begin
            w_hp_n       = r_res;
            w_pend_vld_n = 1'b0;
            w_cnt_n      = '0;
            w_tone_n     = 1'b0;
        end else begin
            if (r_res_vld) begin
                w_pend_n     = r_res;
                w_pend_vld_n = 1'b1;
            end
            if (!enable) begin
                w_cnt_n  = '0;
                w_tone_n = 1'b0;
            end else if (r_hp != '0) begin
                if (r_cnt == r_hp - c_one) begin
                    w_cnt_n  = '0;
                    w_tone_n = ~r_tone;
                    // Retune only on a toggle edge so no half-cycle is ever truncated.
                    if (w_pend_vld_n) begin
                        w_hp_n       = w_pend_n;
                        w_pend_vld_n = 1'b0;
                    end
                end else begin
                    w_cnt_n = r_cnt + c_one;
                end
            end
        end
        w_active_n = enable && (w_hp_n != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hp       <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_cnt      <= '0;
            r_tone     <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_hp       <= w_hp_n;
            r_pend     <= w_pend_n;
            r_pend_vld <= w_pend_vld_n;
            r_cnt      <= w_cnt_n;
            r_tone     <= w_tone_n;
            r_active   <= w_active_n;
        end
    end

    assign freq_ready  = r_ready;
    assign tone_out    = r_tone;
    assign active      = r_active;
    assign half_period = r_hp;

endmodule
`default_nettype wire

// File: tb/tb_tone_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tone_gen
//  Purpose  : Scoreboard bench for tone_gen (1 kHz and 50 MHz instances).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tone_gen;

    localparam int unsigned LO_CLK = 1000;
    localparam int unsigned HI_CLK = 50_000_000;
    localparam int          CNT_W  = 32;
    localparam int          FREQ_W = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              freq_valid = 1'b0;
    logic [FREQ_W-1:0] freq_x100 = '0;
    logic              enable = 1'b0;
    logic              freq_ready;
    logic              tone_out;
    logic              active;
    logic [CNT_W-1:0]  half_period;

    logic              hs_valid = 1'b0;
    logic [FREQ_W-1:0] hs_freq = '0;
    logic              hs_en = 1'b0;
    logic              hs_ready;
    logic              hs_tone;
    logic              hs_active;
    logic [CNT_W-1:0]  hs_hp;

    always #5 clk = ~clk;

    tone_gen #(.CLK_HZ(LO_CLK), .FREQ_W(FREQ_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .freq_valid(freq_valid), .freq_ready(freq_ready),
        .freq_x100(freq_x100), .enable(enable), .tone_out(tone_out),
        .active(active), .half_period(half_period)
    );

    tone_gen #(.CLK_HZ(HI_CLK), .FREQ_W(FREQ_W), .CNT_W(CNT_W)) dut_hs (
        .clk(clk), .rst_n(rst_n), .freq_valid(hs_valid), .freq_ready(hs_ready),
        .freq_x100(hs_freq), .enable(hs_en), .tone_out(hs_tone),
        .active(hs_active), .half_period(hs_hp)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: half-period = floor(clk*100/2 / f), zero quotient pinned to 1, f=0 mutes.
    function automatic longint unsigned ref_hp(input longint unsigned clk_hz, input longint unsigned f);
        longint unsigned q;
        if (f == 0) return 0;
        q = (clk_hz * 100 / 2) / f;
        return (q == 0) ? 1 : q;
    endfunction

    longint unsigned exp_q[$];
    longint unsigned exp_last = 0;

    task automatic push_exp(input longint unsigned e);
        if (e != exp_last) begin
            exp_q.push_back(e);
            exp_last = e;
        end
    endtask

    int   cyc = 0;
    logic en_smp = 1'b0;
    logic x_nz = 1'b0;
    logic x_z = 1'b0;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        en_smp <= enable;
        x_nz   <= freq_valid && freq_ready && (freq_x100 != '0);
        x_z    <= freq_valid && freq_ready && (freq_x100 == '0);
    end

    longint unsigned m_last_hp = 0;
    longint unsigned m_hp_ref = 0;
    int              m_ref = 0;
    logic            m_last_tone = 1'b0;
    int              m_low = 0;

    // Monitor: scoreboard on half_period changes plus waveform/handshake observation.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_last_hp   = 0;
            m_last_tone = 1'b0;
            m_ref       = cyc;
            m_hp_ref    = 0;
            m_low       = 0;
        end else begin
            if (64'(half_period) != m_last_hp) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL hp_unexpected: got %0d, want unchanged %0d", half_period, m_last_hp);
                end else begin
                    check("hp_apply", half_period, exp_q.pop_front());
                end
                if (m_last_hp != 0 && half_period != 0)
                    check("retune_on_toggle", 64'(tone_out != m_last_tone), 1);
            end

            if (!en_smp || half_period == 0) begin
                check("silent_tone", tone_out, 0);
                m_ref    = cyc;
                m_hp_ref = half_period;
            end else if (m_last_hp == 0) begin
                m_ref    = cyc;
                m_hp_ref = half_period;
            end else if (tone_out != m_last_tone) begin
                check("half_cycle_len", 64'(cyc - m_ref), m_hp_ref);
                m_ref    = cyc;
                m_hp_ref = half_period;
            end

            check("active", active, 64'(en_smp && (half_period != 0)));
            if (x_nz) check("ready_drop", freq_ready, 0);
            if (x_z)  check("ready_kept_on_mute", freq_ready, 1);
            if (!freq_ready) begin
                m_low++;
            end else if (m_low != 0) begin
                check("ready_low_len", m_low, CNT_W);
                m_low = 0;
            end
            m_last_hp   = half_period;
            m_last_tone = tone_out;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!freq_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!freq_ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got ready=0 after %0d cycles, want 1", n);
        end
    endtask

    task automatic send(input logic [FREQ_W-1:0] f);
        wait_ready(100);
        freq_valid = 1'b1;
        freq_x100  = f;
        push_exp(ref_hp(LO_CLK, 64'(f)));
        @(negedge clk);
        freq_valid = 1'b0;
    endtask

    task automatic wait_hp(input longint unsigned e, input int budget);
        int n = 0;
        while (64'(half_period) != e && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("apply_wait", half_period, e);
    endtask

    task automatic reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_tone"}, tone_out, 0);
        check({tag, "_ready"}, freq_ready, 1);
        check({tag, "_hp"}, half_period, 0);
        check({tag, "_active"}, active, 0);
        exp_last = 0;
        idle(2);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish within 100000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int              n;
        logic [FREQ_W-1:0] f;
        longint unsigned e;

        enable = 1'b1;
        hs_en  = 1'b1;
        idle(3);
        check("rst_tone", tone_out, 0);
        check("rst_ready", freq_ready, 1);
        check("rst_hp", half_period, 0);
        check("rst_active", active, 0);
        rst_n = 1'b1;
        idle(1);

        // Full-scale values on the 50 MHz instance.
        hs_valid = 1'b1; hs_freq = 20'd22000;
        @(negedge clk);
        hs_valid = 1'b0;
        check("hs_busy", hs_ready, 0);
        idle(40);
        check("hs_hp_22000", hs_hp, ref_hp(HI_CLK, 22000));
        check("hs_hp_22000_const", hs_hp, 113636);
        check("hs_active_on", hs_active, 1);
        hs_valid = 1'b1; hs_freq = '0;
        @(negedge clk);
        hs_valid = 1'b0;
        check("hs_mute_hp", hs_hp, 0);
        check("hs_mute_active", hs_active, 0);
        hs_valid = 1'b1; hs_freq = 20'd13081;
        @(negedge clk);
        hs_valid = 1'b0;
        idle(40);
        check("hs_hp_13081", hs_hp, 191116);
        hs_en = 1'b0;
        idle(3);
        check("hs_gate_tone", hs_tone, 0);
        check("hs_gate_hp_kept", hs_hp, 191116);
        check("hs_gate_active", hs_active, 0);
        hs_en = 1'b1;
        idle(2);
        check("hs_reenable_active", hs_active, 1);
        check("hs_reenable_tone", hs_tone, 0);

        // Basic tone, retune, clamp, mute.
        send(20'd100);
        wait_hp(500, 100);
        idle(2100);
        send(20'd2500);
        wait_hp(20, 600);
        idle(100);
        send(20'd60000);
        wait_hp(1, 100);
        idle(20);
        send('0);
        check("mute_tone", tone_out, 0);
        check("mute_active", active, 0);
        check("mute_hp", half_period, 0);

        // Back-pressure: second request held through the division.
        wait_ready(100);
        freq_valid = 1'b1;
        freq_x100  = 20'd25000;
        push_exp(ref_hp(LO_CLK, 25000));
        @(negedge clk);
        check("bp_busy", freq_ready, 0);
        freq_x100 = 20'd10000;
        n = 0;
        while (!freq_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_wait_len", n, CNT_W);
        push_exp(ref_hp(LO_CLK, 10000));
        @(negedge clk);
        check("bp_accept_same_cycle", freq_ready, 0);
        freq_valid = 1'b0;
        wait_hp(2, 10);
        wait_hp(5, 100);
        idle(20);

        // Enable gating.
        enable = 1'b0;
        idle(20);
        check("gate_hp_kept", half_period, 5);
        check("gate_tone", tone_out, 0);
        check("gate_active", active, 0);
        enable = 1'b1;
        idle(60);

        // Randomized requests.
        for (int i = 0; i < 14; i++) begin
            case ($urandom_range(0, 9))
                0:       f = '0;
                1:       f = FREQ_W'($urandom_range(50001, 1048575));
                default: f = FREQ_W'($urandom_range(250, 50000));
            endcase
            e = ref_hp(LO_CLK, 64'(f));
            send(f);
            wait_hp(e, 1500);
            idle($urandom_range(0, 200));
            if ($urandom_range(0, 3) == 0) begin
                enable = 1'b0;
                idle($urandom_range(1, 20));
                enable = 1'b1;
            end
        end

        // Reset during a division, then during a running tone.
        send('0);
        send(20'd100);
        idle(10);
        reset_pulse("rst_div");
        idle(50);
        check("no_stale_hp", half_period, 0);
        send(20'd5000);
        wait_hp(10, 100);
        idle(37);
        reset_pulse("rst_run");
        idle(20);
        check("post_rst_hp", half_period, 0);
        check("post_rst_tone", tone_out, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
